// File: rtl/text_pkg.sv
// Shared constants and reader FSM state type for the text RAM read path.
package text_pkg;
    localparam int TEXT_RAM_WIDTH = 39;
    localparam int TEXT_RAM_DEPTH = 64;
    localparam int TEXT_ADDR_W    = 6;
    localparam int TEXT_VALID_BIT = 38;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2
    } readerState_t;
endpackage

// File: rtl/text_reader_fifo.sv
// Small synchronous FIFO with occupancy count; head entry is presented combinationally.
module text_reader_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 45
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic             w_pop;

    assign w_pop   = i_pop && (r_count != '0);
    assign o_data  = r_mem[r_rdPtr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

    // Storage is cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wrPtr] <= i_data;
                r_wrPtr        <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // The reader's credit scheme must never push into a full FIFO without a pop.
    assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_push && !w_pop && (r_count == CNT_W'(DEPTH))));
endmodule

// File: rtl/text_ram_reader.sv
// Sweeps the text RAM through port B and streams {entry, index} over valid/ready,
// hiding the 2-cycle read latency with an in-flight tracker and output FIFO.
module text_ram_reader
    import text_pkg::*;
#(
    parameter int  RAM_WIDTH     = TEXT_RAM_WIDTH,
    parameter int  RAM_DEPTH     = TEXT_RAM_DEPTH,
    parameter int  FIFO_DEPTH    = 4,
    parameter bit  STOP_ON_EMPTY = 1'b1,
    localparam int ADDR_W        = $clog2(RAM_DEPTH)
) (
    input  logic                 clka,
    input  logic                 rsta,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W-1:0]    ram_addrb,
    output logic                 ram_enb,
    output logic                 ram_regceb,
    output logic                 ram_rstb,
    input  logic [RAM_WIDTH-1:0] ram_doutb,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [RAM_WIDTH-1:0] m_data,
    output logic [ADDR_W-1:0]    m_index
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SUM_W = CNT_W + 1;

    readerState_t         r_state;
    logic [ADDR_W-1:0]    r_nextAddr;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_flush;
    logic                 r_s1Valid;
    logic [ADDR_W-1:0]    r_s1Index;
    logic                 r_s2Valid;
    logic [ADDR_W-1:0]    r_s2Index;

    logic [CNT_W-1:0]     w_fifoCount;
    logic                 w_fifoEmpty;
    logic [SUM_W-1:0]     w_used;
    logic                 w_issue;
    logic                 w_terminator;
    logic                 w_push;
    logic                 w_pop;

    // Credits count both FIFO entries and reads still in the RAM pipeline.
    assign w_used       = SUM_W'(w_fifoCount) + SUM_W'(r_s1Valid) + SUM_W'(r_s2Valid);
    assign w_issue      = (r_state == ST_SWEEP) && (w_used < SUM_W'(FIFO_DEPTH));
    assign w_terminator = r_s2Valid && !r_flush && STOP_ON_EMPTY && !ram_doutb[RAM_WIDTH-1];
    assign w_push       = r_s2Valid && !r_flush && !w_terminator;
    assign w_pop        = m_valid && m_ready;

    assign busy       = r_busy;
    assign done       = r_done;
    assign ram_enb    = w_issue;
    assign ram_addrb  = w_issue ? r_nextAddr : '0;
    assign ram_regceb = r_busy;
    assign ram_rstb   = 1'b0;
    assign m_valid    = !w_fifoEmpty;

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            r_state    <= ST_IDLE;
            r_nextAddr <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_flush    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_SWEEP;
                        r_busy     <= 1'b1;
                        r_nextAddr <= '0;
                        r_flush    <= 1'b0;
                    end
                end
                ST_SWEEP: begin
                    if (w_issue) begin
                        r_nextAddr <= r_nextAddr + 1'b1;
                    end
                    if (w_terminator) begin
                        r_flush <= 1'b1;
                        r_state <= ST_DRAIN;
                    end else if (w_issue && (r_nextAddr == ADDR_W'(RAM_DEPTH - 1))) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_terminator) begin
                        r_flush <= 1'b1;
                    end
                    if (!r_s1Valid && !r_s2Valid && w_fifoEmpty) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_flush <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Mirrors the RAM read pipeline: stage 2 lines up with valid ram_doutb.
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            r_s1Valid <= 1'b0;
            r_s1Index <= '0;
            r_s2Valid <= 1'b0;
            r_s2Index <= '0;
        end else begin
            r_s1Valid <= w_issue;
            r_s1Index <= r_nextAddr;
            r_s2Valid <= r_s1Valid;
            r_s2Index <= r_s1Index;
        end
    end

    text_reader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (RAM_WIDTH + ADDR_W)
    ) u_fifo (
        .i_clk   (clka),
        .i_rst   (rsta),
        .i_push  (w_push),
        .i_data  ({ram_doutb, r_s2Index}),
        .i_pop   (w_pop),
        .o_data  ({m_data, m_index}),
        .o_count (w_fifoCount),
        .o_empty (w_fifoEmpty)
    );
endmodule

// File: doc/text_ram_reader.md
Name: text_ram_reader

Overview:
- Read-side sequencer for the 39-bit x 64-entry simple-dual-port text RAM; drives its port B (addrb/enb/regceb/rstb) and consumes doutb.
- On a start pulse, sweeps entries from address 0 and streams each one, with its index, to the text renderer over a valid/ready interface.
- Hides the RAM's 2-cycle read latency with a credit-limited in-flight tracker plus a small output FIFO, so that backpressure never loses an entry.
- Optionally stops at the first empty entry (marker bit clear).

Parameters:
- RAM_WIDTH, 39, entry width; must match the RAM.
- RAM_DEPTH, 64, number of entries; ADDR_W = clog2(RAM_DEPTH) = 6.
- FIFO_DEPTH, 4, output FIFO entries; must be a power of 2 and at least 4.
- STOP_ON_EMPTY, 1, when 1 an entry with bit [RAM_WIDTH-1]==0 terminates the sweep.

Ports:
- clka  in  1  clock, shared with the RAM.
- rsta  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle request to begin a sweep; ignored while busy=1.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the sweep is finished and every entry has been popped.
- ram_addrb  out  ADDR_W  RAM read address.
- ram_enb  out  1  RAM read enable; high only in issue cycles.
- ram_regceb  out  1  RAM output register enable; equals busy.
- ram_rstb  out  1  tied 0.
- ram_doutb  in  RAM_WIDTH  RAM read data, valid 2 edges after the issue edge.
- m_valid  out  1  output entry valid.
- m_ready  in  1  consumer accepts the entry.
- m_data  out  RAM_WIDTH  entry contents.
- m_index  out  ADDR_W  address the entry was read from.

Behaviour:
- Reset (async, any state): busy=0, done=0, ram_addrb=0, ram_enb=0, m_valid=0, m_data=0, m_index=0. The FIFO, in-flight tracker and flush flag are all cleared. RAM contents are untouched.
- FSM states:
  - IDLE: start=1 -> SWEEP, next_addr=0.
  - SWEEP: issues reads. Moves to DRAIN after issuing address RAM_DEPTH-1, or on terminator detection.
  - DRAIN: no issues. When both in-flight stages are empty and the FIFO is empty -> IDLE, with done=1 for exactly that one cycle.
- Issue rule, evaluated in SWEEP: issue when fifo_count + inflight_count < FIFO_DEPTH, where inflight_count is 0..2.
  - On issue: ram_enb=1, ram_addrb=next_addr, next_addr increments.
  - Credits are evaluated on registered counts; a same-cycle pop frees its credit only from the next cycle.
- In-flight tracker: two-stage shift register of {valid, index} that mirrors the RAM pipeline. Stage 2 valid means ram_doutb holds that index's entry in the current cycle.
- Capture when stage 2 is valid:
  - If the flush flag is set: the entry is discarded.
  - Else if STOP_ON_EMPTY=1 and ram_doutb[RAM_WIDTH-1]==0: not pushed; set flush, go to DRAIN. Entries already in the tracker are discarded.
  - Else: push {ram_doutb, index} into the FIFO.
- Latency: start sampled at edge E0 -> addr 0 issued in the cycle after E0 -> pushed at E3 -> m_valid=1 in the cycle after E3.
- Throughput: with m_ready held at 1, one entry per cycle is sustained.
- Output: m_valid = FIFO not empty; m_data and m_index come from the FIFO head. A pop occurs on m_valid && m_ready. A simultaneous push and pop leaves the count unchanged.
- Overflow is impossible by the credit rule; an implementation assertion guards it.
- start while busy=1 is ignored and has no effect. start in the same cycle as done is accepted.
- next_addr does not wrap within a sweep; a new sweep restarts at 0.

Decomposition:
- Shared package text_pkg holds:
  - TEXT_RAM_WIDTH = 39, TEXT_RAM_DEPTH = 64, TEXT_ADDR_W = 6;
  - TEXT_VALID_BIT = 38;
  - the reader FSM state enum.
- One sub-module: text_reader_fifo, a synchronous FIFO of FIFO_DEPTH x (RAM_WIDTH+ADDR_W) with count output and async reset.

Test Plan:
- Full sweep: all 64 entries have bit 38 set and value = index; start pulse; m_ready=1 -> 64 beats with m_index 0..63 in order, first m_valid 3 edges after start, no gaps, one done pulse after beat 63.
- Terminator: entry 5 = 0, entries 0..4 valid -> exactly 5 beats (0..4), reads of 6..7 discarded, done pulse, busy=0.
- Backpressure: m_ready low for 20 cycles, then toggling 1/0 -> no loss or duplication; ram_enb never issues with fifo_count + inflight = 4; all 64 delivered.
- Reset mid-sweep: assert rsta at beat 10 -> all outputs return to reset values immediately; the next start replays from index 0.
- start while busy: pulse start at beat 30 -> ignored, a single done pulse, 64 beats total.
- STOP_ON_EMPTY=0 with all-zero RAM -> 64 beats of m_data=0, done pulse.
